// File: rtl/mem_arbiter.sv
// Single-port data RAM arbiter: CPU memory stage vs external bus master, with read-owner tagging.
// Define ARB_STARVE_GUARD_EN to add the external-master starvation guard (STARVE_LIMIT).
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_chk
      $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
   end

   logic cpu_gnt;
   logic force_ext;
   logic rd_cpu_q, rd_ext_q;

`ifdef ARB_STARVE_GUARD_EN
   logic [7:0] starve_q, starve_d;

   assign force_ext = cpu_req & ext_req & (starve_q == 8'(STARVE_LIMIT));

   // Counts consecutive contested cycles the external master lost.
   always_comb begin
      starve_d = starve_q;
      if (!ext_req || ext_gnt) begin
         starve_d = 8'd0;
      end else if (cpu_req) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= 8'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_ext = 1'b0;
`endif

   // Grants are masked during reset so requests in that cycle are dropped.
   always_comb begin
      cpu_gnt   = ~rst & cpu_req & ~force_ext;
      ext_gnt   = ~rst & ext_req & (~cpu_req | force_ext);
      cpu_stall = ~rst & cpu_req & ~cpu_gnt;
   end

   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      ram_we   = cpu_gnt & cpu_we;
      if (ext_gnt) begin
         ram_addr = ext_addr;
         ram_din  = ext_wdata;
         ram_we   = ext_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cpu_q <= 1'b0;
         rd_ext_q <= 1'b0;
      end else begin
         rd_cpu_q <= cpu_gnt & ~cpu_we;
         rd_ext_q <= ext_gnt & ~ext_we;
      end
   end

   // A read tagged just before reset never reports valid while rst is high.
   assign cpu_rvalid = rd_cpu_q & ~rst;
   assign ext_rvalid = rd_ext_q & ~rst;
   assign cpu_rdata  = ram_dout;
   assign ext_rdata  = ram_dout;

endmodule
